// File: rtl/bf_candidate_engine.sv
// Brute-force candidate engine: enumerates NUM_CHARS-symbol words over ALPHABET symbols,
// first symbol restricted to [from, to], offered on a valid/ready stream and compared to a target.
module bf_candidate_engine #(
   parameter int NUM_CHARS = 4,
   parameter int ALPHABET  = 36,
   parameter int SYM_W     = 6,
   parameter int CNT_W     = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic [NUM_CHARS*SYM_W-1:0] target,
   input  logic [SYM_W-1:0]           from,
   input  logic [SYM_W-1:0]           to,
   output logic [NUM_CHARS*SYM_W-1:0] cand,
   output logic                       cand_valid,
   input  logic                       cand_ready,
   output logic                       busy,
   output logic                       found,
   output logic                       done,
   output logic [NUM_CHARS*SYM_W-1:0] match,
   output logic [CNT_W-1:0]           count
);

   localparam int WORD_W = NUM_CHARS * SYM_W;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_RUN       = 3'd1;
   localparam logic [2:0] ST_HIT       = 3'd2;
   localparam logic [2:0] ST_EXHAUSTED = 3'd3;
   localparam logic [2:0] ST_ABORTED   = 3'd4;

   localparam logic [SYM_W-1:0] SYM_MAX   = SYM_W'(ALPHABET - 1);
   localparam logic [SYM_W-1:0] SYM_ONE   = SYM_W'(1);
   localparam logic [SYM_W:0]   SYM_LIMIT = (SYM_W + 1)'(ALPHABET);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [2:0]        state_r;
   logic [WORD_W-1:0] cand_r;
   logic [WORD_W-1:0] target_r;
   logic [SYM_W-1:0]  to_r;
   logic [WORD_W-1:0] match_r;
   logic [CNT_W-1:0]  count_r;
   logic              found_r;
   logic              done_r;
   logic              cand_valid_r;
   logic              busy_r;

   logic [WORD_W-1:0] next_cand_s;
   logic [WORD_W-1:0] last_cand_s;
   logic [WORD_W-1:0] start_cand_s;
   logic [SYM_W-1:0]  sym_s;
   logic              carry_s;
   logic              range_bad_s;
   logic              hs_s;

   assign cand       = cand_r;
   assign cand_valid = cand_valid_r;
   assign busy       = busy_r;
   assign found      = found_r;
   assign done       = done_r;
   assign match      = match_r;
   assign count      = count_r;

   assign hs_s         = cand_valid_r & cand_ready;
   assign last_cand_s  = {to_r, {(NUM_CHARS - 1){SYM_MAX}}};
   assign start_cand_s = {from, {((NUM_CHARS - 1) * SYM_W){1'b0}}};
   assign range_bad_s  = (from > to) || ({1'b0, to} >= SYM_LIMIT);

   // Odometer increment: symbol slice 0 (LSBs) is the last symbol and changes fastest.
   always_comb begin
      next_cand_s = cand_r;
      carry_s     = 1'b1;
      sym_s       = '0;
      for (int i = 0; i < NUM_CHARS; i++) begin
         sym_s = cand_r[i*SYM_W +: SYM_W];
         if (carry_s) begin
            if (sym_s == SYM_MAX) begin
               next_cand_s[i*SYM_W +: SYM_W] = {SYM_W{1'b0}};
            end else begin
               next_cand_s[i*SYM_W +: SYM_W] = sym_s + SYM_ONE;
               carry_s = 1'b0;
            end
         end else begin
            next_cand_s[i*SYM_W +: SYM_W] = sym_s;
         end
      end
   end

   // Search control: start/abort handling, handshake accounting and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         cand_r       <= '0;
         target_r     <= '0;
         to_r         <= '0;
         match_r      <= '0;
         count_r      <= '0;
         found_r      <= 1'b0;
         done_r       <= 1'b0;
         cand_valid_r <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (hs_s) begin
                  count_r <= count_r + CNT_ONE;
                  // A hit outranks both exhaustion and a concurrent abort.
                  if (cand_r == target_r) begin
                     match_r      <= cand_r;
                     found_r      <= 1'b1;
                     done_r       <= 1'b1;
                     state_r      <= ST_HIT;
                     cand_valid_r <= 1'b0;
                     busy_r       <= 1'b0;
                  end else if (cand_r == last_cand_s) begin
                     done_r       <= 1'b1;
                     state_r      <= ST_EXHAUSTED;
                     cand_valid_r <= 1'b0;
                     busy_r       <= 1'b0;
                  end else begin
                     cand_r <= next_cand_s;
                     if (abort) begin
                        done_r       <= 1'b1;
                        state_r      <= ST_ABORTED;
                        cand_valid_r <= 1'b0;
                        busy_r       <= 1'b0;
                     end
                  end
               end else if (abort) begin
                  done_r       <= 1'b1;
                  state_r      <= ST_ABORTED;
                  cand_valid_r <= 1'b0;
                  busy_r       <= 1'b0;
               end
            end
            ST_IDLE, ST_HIT, ST_EXHAUSTED, ST_ABORTED: begin
               if (start) begin
                  target_r <= target;
                  to_r     <= to;
                  found_r  <= 1'b0;
                  count_r  <= '0;
                  cand_r   <= start_cand_s;
                  if (range_bad_s) begin
                     done_r       <= 1'b1;
                     state_r      <= ST_EXHAUSTED;
                     cand_valid_r <= 1'b0;
                     busy_r       <= 1'b0;
                  end else begin
                     done_r       <= 1'b0;
                     state_r      <= ST_RUN;
                     cand_valid_r <= 1'b1;
                     busy_r       <= 1'b1;
                  end
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               cand_valid_r <= 1'b0;
               busy_r       <= 1'b0;
            end
         endcase
      end
   end

endmodule
